status_register_unit: RTL and testbench

//  Writer side of the NZCV status interface. Derives N/Z/C/V from the EXE-stage ALU

---
 rtl/status_register_unit_if.sv | 34 +++
 rtl/status_register_unit.sv | 73 +++++++
 tb/tb_status_register_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/status_register_unit_if.sv
// NZCV status bus between the EXE stage and the status register unit.
// master drives ALU flag sources and control; slave returns the status views.
interface status_register_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] aluResult;
    logic             aluCarry;
    logic             aluOverflow;
    logic             shiftCarry;
    logic             isLogical;
    logic             sBit;
    logic             valid;
    logic             flush;
    logic             stall;
    logic             saveReq;
    logic             restoreReq;
    logic [3:0]       statusOut;
    logic [3:0]       savedStatusOut;
    logic             updated;

    modport master (
        output aluResult, aluCarry, aluOverflow, shiftCarry,
        output isLogical, sBit, valid, flush, stall,
        output saveReq, restoreReq,
        input  statusOut, savedStatusOut, updated
    );

    modport slave (
        input  aluResult, aluCarry, aluOverflow, shiftCarry,
        input  isLogical, sBit, valid, flush, stall,
        input  saveReq, restoreReq,
        output statusOut, savedStatusOut, updated
    );
endinterface

// File: rtl/status_register_unit.sv
// NZCV writer: derives flags from the EXE result, holds CPSR and SPSR.
// Define STATUS_BYPASS_EN to forward next-edge CPSR onto statusOut.
module status_register_unit #(
    parameter int         WIDTH       = 32,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input logic                   clk,
    input logic                   rst,
    status_register_unit_if.slave bus
);
    logic [3:0] cpsr;
    logic [3:0] spsr;
    logic [3:0] cpsrNext;
    logic [3:0] spsrNext;
    logic [3:0] derived;
    logic       wr;
    logic       updatedQ;
    logic       updatedNext;

    // Logical ops keep V from the current CPSR.
    always_comb begin
        derived[3] = bus.aluResult[WIDTH-1];
        derived[2] = (bus.aluResult == '0);
        if (bus.isLogical) begin
            derived[1] = bus.shiftCarry;
            derived[0] = cpsr[0];
        end else begin
            derived[1] = bus.aluCarry;
            derived[0] = bus.aluOverflow;
        end
    end

    assign wr = bus.sBit & bus.valid & ~bus.flush & ~bus.stall;

    // Restore beats a same-edge write; save always captures the old CPSR.
    always_comb begin
        cpsrNext    = cpsr;
        spsrNext    = spsr;
        updatedNext = updatedQ;
        if (!bus.stall) begin
            if (bus.restoreReq) begin
                cpsrNext = spsr;
            end else if (wr) begin
                cpsrNext = derived;
            end
            if (bus.saveReq) begin
                spsrNext = cpsr;
            end
            updatedNext = (cpsrNext != cpsr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpsr     <= RESET_FLAGS;
            spsr     <= RESET_FLAGS;
            updatedQ <= 1'b0;
        end else begin
            cpsr     <= cpsrNext;
            spsr     <= spsrNext;
            updatedQ <= updatedNext;
        end
    end

`ifdef STATUS_BYPASS_EN
    assign bus.statusOut = rst ? cpsrNext : RESET_FLAGS;
`else
    assign bus.statusOut = cpsr;
`endif

    assign bus.savedStatusOut = spsr;
    assign bus.updated        = updatedQ;
endmodule

// File: tb/tb_status_register_unit.sv
// Randomised bench for status_register_unit against an NZCV reference model.
// Directed cases cover reset, SUBS, logical V-hold, suppression, save/restore.
module tb_status_register_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    status_register_unit_if #(.WIDTH(W)) bus ();

    status_register_unit #(
        .WIDTH(W),
        .RESET_FLAGS(4'b0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int nChecks = 0;
    int nPass   = 0;

    logic [3:0] mCpsr;
    logic [3:0] mSpsr;
    logic       mUpd;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Flags as the architecture defines them for the current result.
    function automatic logic [3:0] flagsFor();
        logic n, z, c, v;
        n = (bus.aluResult >> (W - 1)) != 0;
        z = bus.aluResult == 0;
        c = bus.isLogical ? bus.shiftCarry : bus.aluCarry;
        v = bus.isLogical ? mCpsr[0] : bus.aluOverflow;
        return {n, z, c, v};
    endfunction

    function automatic logic [3:0] cpsrAfter();
        if (bus.stall) return mCpsr;
        if (bus.restoreReq) return mSpsr;
        if (bus.sBit && bus.valid && !bus.flush) return flagsFor();
        return mCpsr;
    endfunction

    function automatic logic [3:0] spsrAfter();
        if (!bus.stall && bus.saveReq) return mCpsr;
        return mSpsr;
    endfunction

    function automatic logic [3:0] expStatus();
`ifdef STATUS_BYPASS_EN
        return cpsrAfter();
`else
        return mCpsr;
`endif
    endfunction

    task automatic idle();
        bus.aluResult   = '0;
        bus.aluCarry    = 0;
        bus.aluOverflow = 0;
        bus.shiftCarry  = 0;
        bus.isLogical   = 0;
        bus.sBit        = 0;
        bus.valid       = 0;
        bus.flush       = 0;
        bus.stall       = 0;
        bus.saveReq     = 0;
        bus.restoreReq  = 0;
    endtask

    task automatic arith(input logic [31:0] r, input logic c,
                         input logic v);
        idle();
        bus.aluResult   = r;
        bus.aluCarry    = c;
        bus.aluOverflow = v;
        bus.sBit        = 1;
        bus.valid       = 1;
    endtask

    // Inputs are already applied; check, clock one edge, check again.
    task automatic step(input string tag);
        logic [3:0] nC, nS;
        logic       nU;
        #1;
        chk({tag, "/pre"}, bus.statusOut, expStatus());
        nC = cpsrAfter();
        nS = spsrAfter();
        nU = bus.stall ? mUpd : (nC != mCpsr);
        @(posedge clk);
        mCpsr = nC;
        mSpsr = nS;
        mUpd  = nU;
        #1;
        chk({tag, "/status"}, bus.statusOut, expStatus());
        chk({tag, "/saved"}, bus.savedStatusOut, mSpsr);
        chk({tag, "/upd"}, bus.updated, mUpd);
    endtask

    initial begin
        idle();
        rst = 0;
        mCpsr = 0;
        mSpsr = 0;
        mUpd  = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/status", bus.statusOut, 4'b0000);
        chk("rst/saved", bus.savedStatusOut, 4'b0000);
        chk("rst/upd", bus.updated, 1'b0);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        step("idle");
        chk("idle/status", bus.statusOut, 4'b0000);

        arith(32'h0, 1, 0);
        step("subs");
        chk("subs/nzcv", bus.statusOut, 4'b0110);
        chk("subs/pulse", bus.updated, 1'b1);
        idle();
        step("subs2");
        chk("subs/pulse_end", bus.updated, 1'b0);

        arith(32'h1, 0, 1);
        step("setv");
        chk("setv/nzcv", bus.statusOut, 4'b0001);
        idle();
        bus.aluResult  = 32'h8000_0000;
        bus.shiftCarry = 1;
        bus.isLogical  = 1;
        bus.sBit       = 1;
        bus.valid      = 1;
        step("logic");
        chk("logic/nzcv", bus.statusOut, 4'b1011);

        arith(32'h0, 0, 0);
        bus.flush = 1;
        step("sup_flush");
        chk("sup_flush/upd", bus.updated, 1'b0);
        bus.flush = 0;
        bus.stall = 1;
        step("sup_stall");
        chk("sup_stall/nzcv", bus.statusOut, 4'b1011);
        bus.stall = 0;
        bus.sBit  = 0;
        step("sup_sbit");
        chk("sup_sbit/nzcv", bus.statusOut, 4'b1011);

        arith(32'h0, 0, 0);
        step("cp0100");
        arith(32'h8000_0000, 0, 0);
        bus.saveReq = 1;
        step("savewr");
        chk("savewr/spsr", bus.savedStatusOut, 4'b0100);
        chk("savewr/cpsr", bus.statusOut, 4'b1000);
        arith(32'h1, 1, 0);
        bus.restoreReq = 1;
        step("restwr");
        chk("restwr/cpsr", bus.statusOut, 4'b0100);

        arith(32'h0, 1, 0);
        #1;
`ifdef STATUS_BYPASS_EN
        chk("bypass/pre", bus.statusOut, 4'b0110);
`else
        chk("bypass/pre", bus.statusOut, 4'b0100);
`endif
        step("bypass");
        chk("bypass/post", bus.statusOut, 4'b0110);

        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = $urandom_range(3);
            bus.aluResult   = (sel == 0) ? 32'h0 :
                              (sel == 1) ? 32'h8000_0000 : $urandom;
            bus.aluCarry    = 1'($urandom);
            bus.aluOverflow = 1'($urandom);
            bus.shiftCarry  = 1'($urandom);
            bus.isLogical   = 1'($urandom);
            bus.sBit        = $urandom_range(3) != 0;
            bus.valid       = $urandom_range(3) != 0;
            bus.flush       = $urandom_range(7) == 0;
            bus.stall       = $urandom_range(7) == 0;
            bus.saveReq     = $urandom_range(7) == 0;
            bus.restoreReq  = $urandom_range(7) == 0;
            step("rand");
        end

        arith(32'h8000_0000, 1, 1);
        bus.saveReq = 1;
        @(negedge clk);
        rst = 0;
        #1;
        mCpsr = 0;
        mSpsr = 0;
        mUpd  = 0;
        chk("midrst/status", bus.statusOut, 4'b0000);
        chk("midrst/saved", bus.savedStatusOut, 4'b0000);
        chk("midrst/upd", bus.updated, 1'b0);
        @(posedge clk);
        #1;
        chk("midrst/hold", bus.statusOut, 4'b0000);
        @(negedge clk);
        idle();
        rst = 1;
        step("after_rst");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
